neuron_sequencer: RTL and testbench
===================================

# neuron_sequencer

- Control FSM for one neuron datapath.
- On a `start` request it clears the accumulator, then steps the input/weight selection offset through all `N` elements with accumulate-load asserted.
- It then raises `ready` to gate the activation output and holds a valid/ack handshake with the consumer.
- Sits directly upstream of the neuron datapath and drives its `offset`, `ld`, `clr`, `ready` and `hidden` controls.

## Interface
Parameters:
- `N`, 10: number of input/weight pairs per neuron; legal range N ≥ 2.
- `OW`, `$clog2(N)`: offset width; derived, not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new neuron evaluation; sampled only in IDLE or DONE.
- `hidden_in`  in  1  hidden-layer mode for this evaluation; captured when `start` is accepted.
- `out_ack`  in  1  consumer has taken the result.
- `offset`  out  OW  element index to the datapath.
- `ld`  out  1  accumulator load enable.
- `clr`  out  1  accumulator clear.
- `ready`  out  1  activation output enable.
- `hidden`  out  1  latched hidden-mode flag.
- `busy`  out  1  high in every state except IDLE.
- `out_valid`  out  1  result valid to consumer.

## Operation
States are IDLE, CLEAR, ACCUM and DONE.

- **IDLE**
  - All control outputs are 0 and `offset` = 0.
  - `start`=1 → CLEAR; `hidden` ← `hidden_in`.
- **CLEAR**
  - `clr`=1 for exactly one cycle; `offset` = 0.
  - Unconditional → ACCUM.
- **ACCUM**
  - `ld`=1.
  - `offset` takes 0,1,…,N-1 on consecutive cycles.
  - When `offset`==N-1 → DONE, and `offset` returns to 0.
- **DONE**
  - `ready`=1 and `out_valid`=1, held until `out_ack`.
  - `out_ack`=1 and `start`=0 → IDLE.
  - `out_ack`=1 and `start`=1 → CLEAR directly; `hidden` ← `hidden_in` (back-to-back evaluation).
  - `out_ack`=0 → stay in DONE; `start` is ignored.

Boundary and priority rules:
- `start` in CLEAR or ACCUM is ignored and not queued.
- `hidden` changes only on an accepted `start`; it is stable from CLEAR through DONE.
- `out_ack` outside DONE has no effect.
- `offset` never exceeds N-1 and never wraps inside ACCUM.
- `clr` and `ld` are never high in the same cycle.
- `rst` has priority over everything. Any state, including mid-ACCUM, goes to IDLE on the next edge.
  - Reset values: `offset`=0; `ld`, `clr`, `ready`, `hidden`, `busy`, `out_valid` all 0.

## Timing
- All outputs are registered (Moore); none depend combinationally on inputs.
- `start` accepted at edge t:
  - `clr` high in cycle t+1.
  - `ld` high in cycles t+2 … t+N+1, with `offset` = cycle − (t+2).
  - `out_valid`/`ready` high from cycle t+N+2.
- Minimum period between accepted starts is N+2 cycles; this is achieved when `start` and `out_ack` coincide with the first DONE cycle.
- `out_ack` sampled at edge e drops `out_valid` and `ready` in cycle e+1.
- `busy` rises in the cycle after `start` is accepted and falls in the cycle after the final ack.
- `busy` stays high through a back-to-back start.

## Structure
- Shared package `neuron_pkg` holds:
  - the state encodings as localparams (IDLE=2'd0, CLEAR=2'd1, ACCUM=2'd2, DONE=2'd3);
  - the `N`/`OW` defaults, so the datapath and sequencer agree.
- One sub-module: `neuron_offset_counter`, a mod-N up-counter.
  - Inputs: `clk`, `rst`, synchronous `clr`, `en`.
  - Outputs: `count [OW-1:0]` and a `last` flag (`count`==N-1).
  - The FSM uses `last` for the ACCUM→DONE transition.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `offset`=0, `busy`=0.
- N=10, `start` at edge 0 with `hidden_in`=1 → response:
  - `clr` in cycle 1;
  - `ld` in cycles 2–11 with `offset` 0…9;
  - `out_valid`=`ready`=1 from cycle 12 and `hidden`=1 throughout;
  - `out_ack` at cycle 15 → IDLE in cycle 16.
- In DONE, assert `start`+`out_ack` together with `hidden_in`=0 → `clr` on the next cycle, no IDLE cycle between, `hidden` becomes 0.
- Pulse `start` in cycles 3 and 7 while in ACCUM → sequence unchanged; exactly one evaluation; DONE reached at cycle 12.
- Assert `rst` in cycle 6, mid-ACCUM → cycle 7 shows all outputs 0 and `offset`=0; a new `start` afterwards runs a full 10-element sequence.
- N=2 build → `ld` for exactly 2 cycles with `offset` 0,1; `out_valid` from t+4; withheld `out_ack` for 20 cycles → `out_valid` and `ready` held steady.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath and its control sequencer.
// State encodings and element-count defaults live here so both sides agree.
package neuron_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    ACCUM = ST_ACCUM,
    DONE  = ST_DONE
  } state_e;

  localparam int N_DEFAULT  = 10;
  localparam int OW_DEFAULT = $clog2(N_DEFAULT);

endpackage

// File: rtl/neuron_offset_counter.sv
// Mod-N element index counter; flags the final element so the sequencer
// knows when the accumulate pass is complete.
module neuron_offset_counter
  import neuron_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int OW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [OW-1:0] count,
  output logic          last
);

  logic [OW-1:0] count_q, count_d;

  assign last  = (count_q == OW'(N - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Control FSM for one neuron: clear, accumulate N elements, then present the
// result under a valid/ack handshake. All control outputs are registered.
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int OW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hidden_in,
  input  logic          out_ack,
  output logic [OW-1:0] offset,
  output logic          ld,
  output logic          clr,
  output logic          ready,
  output logic          hidden,
  output logic          busy,
  output logic          out_valid
);

  state_e state_q, state_d;
  logic   hidden_q, hidden_d;
  logic   ld_q, ld_d;
  logic   clr_q, clr_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;
  logic   accept;
  logic   last;

  neuron_offset_counter #(.N(N)) u_offset (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != ACCUM),
    .en    (state_q == ACCUM),
    .count (offset),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          accept  = 1'b1;
        end
      end
      CLEAR: state_d = ACCUM;
      ACCUM: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        // start is only honoured together with the ack (back-to-back run)
        if (out_ack) begin
          if (start) begin
            state_d = CLEAR;
            accept  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    hidden_d = accept ? hidden_in : hidden_q;
    ld_d     = (state_d == ACCUM);
    clr_d    = (state_d == CLEAR);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hidden_q <= 1'b0;
      ld_q     <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hidden_q <= hidden_d;
      ld_q     <= ld_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign ld        = ld_q;
  assign clr       = clr_q;
  assign ready     = done_q;
  assign out_valid = done_q;
  assign busy      = busy_q;
  assign hidden    = hidden_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: an N=10 and an N=2 instance checked every cycle
// against a cycles-since-start model, plus directed literal expectations.
module tb_neuron_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_i, start_i, hin_i, ack_i;
  logic [3:0] off0;
  logic [0:0] off1;
  logic [1:0] ld_o, clr_o, rdy_o, hid_o, busy_o, vld_o;

  neuron_sequencer #(.N(10)) u0 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .hidden_in(hin_i[0]),
    .out_ack(ack_i[0]), .offset(off0), .ld(ld_o[0]), .clr(clr_o[0]),
    .ready(rdy_o[0]), .hidden(hid_o[0]), .busy(busy_o[0]), .out_valid(vld_o[0])
  );

  neuron_sequencer #(.N(2)) u1 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .hidden_in(hin_i[1]),
    .out_ack(ack_i[1]), .offset(off1), .ld(ld_o[1]), .clr(clr_o[1]),
    .ready(rdy_o[1]), .hidden(hid_o[1]), .busy(busy_o[1]), .out_valid(vld_o[1])
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model: per instance, whether an evaluation is live and how many cycles
  // have elapsed since its start was accepted (1 = clear cycle).
  int mn   [2] = '{10, 2};
  int m_act[2] = '{0, 0};
  int m_k  [2] = '{0, 0};
  int m_hid[2] = '{0, 0};

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_i[d]) begin
        m_act[d] = 0; m_k[d] = 0; m_hid[d] = 0;
      end else if (m_act[d] == 0) begin
        if (start_i[d]) begin
          m_act[d] = 1; m_k[d] = 1; m_hid[d] = int'(hin_i[d]);
        end
      end else if (m_k[d] >= mn[d] + 2) begin
        if (ack_i[d]) begin
          if (start_i[d]) begin
            m_k[d] = 1; m_hid[d] = int'(hin_i[d]);
          end else begin
            m_act[d] = 0; m_k[d] = 0;
          end
        end
      end else begin
        m_k[d]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int e_ld, e_clr, e_done, e_off, a_off;
        e_clr  = (m_act[d] != 0 && m_k[d] == 1) ? 1 : 0;
        e_ld   = (m_act[d] != 0 && m_k[d] >= 2 && m_k[d] <= mn[d] + 1) ? 1 : 0;
        e_done = (m_act[d] != 0 && m_k[d] >= mn[d] + 2) ? 1 : 0;
        e_off  = (e_ld != 0) ? m_k[d] - 2 : 0;
        a_off  = (d == 0) ? int'(off0) : int'(off1);
        check($sformatf("m%0d_offset", d), a_off, e_off);
        check($sformatf("m%0d_ld", d), int'(ld_o[d]), e_ld);
        check($sformatf("m%0d_clr", d), int'(clr_o[d]), e_clr);
        check($sformatf("m%0d_ready", d), int'(rdy_o[d]), e_done);
        check($sformatf("m%0d_out_valid", d), int'(vld_o[d]), e_done);
        check($sformatf("m%0d_busy", d), int'(busy_o[d]), m_act[d]);
        check($sformatf("m%0d_hidden", d), int'(hid_o[d]), m_hid[d]);
        check($sformatf("m%0d_clr_ld_excl", d), int'(clr_o[d] & ld_o[d]), 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int nld;
    rst_i = 2'b11; start_i = '0; hin_i = '0; ack_i = '0;
    repeat (2) tick();
    rst_i = '0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (5) tick();
    check("idle_busy", int'(busy_o[0]), 0);
    check("idle_offset", int'(off0), 0);
    check("idle_valid", int'(vld_o[0]), 0);
    check("idle_hidden", int'(hid_o[0]), 0);

    // Basic evaluation, hidden_in=1
    start_i[0] = 1'b1; hin_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0; hin_i[0] = 1'b0;
    check("run1_clr", int'(clr_o[0]), 1);
    check("run1_hidden", int'(hid_o[0]), 1);
    for (int j = 2; j <= 11; j++) begin
      tick();
      check($sformatf("run1_ld_c%0d", j), int'(ld_o[0]), 1);
      check($sformatf("run1_off_c%0d", j), int'(off0), j - 2);
    end
    tick();
    check("run1_valid_c12", int'(vld_o[0]), 1);
    check("run1_ready_c12", int'(rdy_o[0]), 1);
    check("run1_off_done", int'(off0), 0);
    repeat (3) tick();
    check("run1_held_c15", int'(vld_o[0]), 1);
    ack_i[0] = 1'b1;
    tick();
    ack_i[0] = 1'b0;
    check("run1_idle_busy", int'(busy_o[0]), 0);
    check("run1_idle_valid", int'(vld_o[0]), 0);
    check("run1_idle_hidden_kept", int'(hid_o[0]), 1);

    // Back-to-back: start+ack on the first DONE cycle, hidden_in=0
    repeat (2) tick();
    start_i[0] = 1'b1; hin_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    repeat (11) tick();
    check("b2b_first_done", int'(vld_o[0]), 1);
    start_i[0] = 1'b1; ack_i[0] = 1'b1; hin_i[0] = 1'b0;
    tick();
    start_i[0] = 1'b0; ack_i[0] = 1'b0;
    check("b2b_clr", int'(clr_o[0]), 1);
    check("b2b_busy", int'(busy_o[0]), 1);
    check("b2b_hidden", int'(hid_o[0]), 0);
    repeat (11) tick();
    check("b2b_second_done", int'(vld_o[0]), 1);
    ack_i[0] = 1'b1;
    tick();
    ack_i[0] = 1'b0;

    // Stray starts during ACCUM are ignored
    start_i[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      start_i[0] = (j == 3 || j == 7);
    end
    check("stray_done_c12", int'(vld_o[0]), 1);
    ack_i[0] = 1'b1;
    tick();
    ack_i[0] = 1'b0;
    check("stray_single_eval", int'(busy_o[0]), 0);

    // Reset mid-ACCUM, then a clean full run
    start_i[0] = 1'b1; hin_i[0] = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      start_i[0] = 1'b0;
      rst_i[0] = (j == 6);
    end
    check("rst_ld", int'(ld_o[0]), 0);
    check("rst_offset", int'(off0), 0);
    check("rst_busy", int'(busy_o[0]), 0);
    check("rst_hidden", int'(hid_o[0]), 0);
    start_i[0] = 1'b1;
    nld = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      start_i[0] = 1'b0;
      if (ld_o[0]) nld++;
    end
    check("rst_rerun_ld_count", nld, 10);
    check("rst_rerun_done", int'(vld_o[0]), 1);
    ack_i[0] = 1'b1;
    tick();
    ack_i[0] = 1'b0;

    // N=2 instance with a withheld ack
    start_i[1] = 1'b1;
    tick();
    start_i[1] = 1'b0;
    check("n2_clr", int'(clr_o[1]), 1);
    tick();
    check("n2_ld0", int'(ld_o[1]), 1);
    check("n2_off0", int'(off1), 0);
    tick();
    check("n2_ld1", int'(ld_o[1]), 1);
    check("n2_off1", int'(off1), 1);
    tick();
    check("n2_valid_t4", int'(vld_o[1]), 1);
    for (int j = 0; j < 20; j++) begin
      tick();
      check("n2_hold_valid", int'(vld_o[1] & rdy_o[1]), 1);
    end
    ack_i[1] = 1'b1;
    tick();
    ack_i[1] = 1'b0;
    check("n2_idle", int'(busy_o[1]), 0);

    // Randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        start_i[d] = ($urandom_range(0, 3) == 0);
        ack_i[d]   = ($urandom_range(0, 2) == 0);
        hin_i[d]   = 1'($urandom);
        rst_i[d]   = ($urandom_range(0, 199) == 0);
      end
      tick();
    end
    start_i = '0; ack_i = '0; rst_i = '0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
